// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer stage: producer request, read-domain
// Gray pointer in, storage address / exported Gray pointer / status flags out.
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = 4
);
  // Handshake: wr_en is the producer's valid, !wr_full is the ready. A word is
  // accepted on a wr_clk rising edge only when wr_en && !wr_full, with wr_full
  // taken as the registered value during that cycle. wr_en asserted while
  // wr_full=1 is ignored; nothing is queued or remembered.
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_ptr_gray;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic                  wr_full;
  logic                  wr_almost_full;

  modport master (
    output wr_en,
    output rd_ptr_gray,
    input  wr_addr,
    input  wr_ptr_gray,
    input  wr_full,
    input  wr_almost_full
  );

  modport slave (
    input  wr_en,
    input  rd_ptr_gray,
    output wr_addr,
    output wr_ptr_gray,
    output wr_full,
    output wr_almost_full
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/full-flag stage of the async FIFO.
// Optional almost-full flag is enabled with `define FIFO_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic            wr_clk,
  input  logic            wr_rst_n,
  fifo_wptr_full_if.slave bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q,   rq1_d;
  logic [PW-1:0] rq2_q,   rq2_d;
  logic          full_q,  full_d;
  logic          push;

  always_comb begin
    push    = bus.wr_en && !full_q;
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, push};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    rq1_d   = bus.rd_ptr_gray;
    rq2_d   = rq1_q;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    full_d  = (wgray_d == {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]});
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rq1_d;
      rq2_q   <= rq2_d;
      full_q  <= full_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] rbin;
  logic [PW-1:0] fill;
  logic          afull_q, afull_d;

  always_comb begin
    rbin[PW-1] = rq2_q[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rq2_q[i];
    end
    // Occupancy seen from the write side; stale read pointer makes it pessimistic.
    fill    = wbin_d - rbin;
    afull_d = (fill >= AFULL_LVL);
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign bus.wr_almost_full = afull_q;
`else
  assign bus.wr_almost_full = 1'b0;
`endif

  assign bus.wr_addr     = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray = wgray_q;
  assign bus.wr_full     = full_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed vector table, corner sequences, and random
// traffic checked against an occupancy-based reference model.
module tb_fifo_wptr_full;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int LAP   = 32;
  localparam int AFM   = 2;

  logic wr_clk;
  logic wr_rst_n;

  fifo_wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_MARGIN(AFM)) dut (
    .wr_clk  (wr_clk),
    .wr_rst_n(wr_rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // reference model: counts of accepted writes, and a 2-deep delay line of
  // the read pointer as seen by the write domain
  int   m_wcount;
  int   m_wtotal;
  bit   m_full;
  bit   m_af;
  bit   m_push;
  logic [PW-1:0] sync_q[$];

  function automatic int g2b(input logic [PW-1:0] g);
    int b = 0;
    for (int i = PW - 1; i >= 0; i--) begin
      b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input int b);
    logic [PW-1:0] v = PW'(b % LAP);
    return v ^ (v >> 1);
  endfunction

  task automatic model_update(input logic rst_n_i, input logic en_i, input logic [PW-1:0] rd_i);
    int occ;
    if (!rst_n_i) begin
      m_wcount = 0;
      m_wtotal = 0;
      m_full   = 0;
      m_af     = 0;
      m_push   = 0;
      sync_q   = {'0, '0};
    end else begin
      m_push   = en_i && !m_full;
      m_wcount = (m_wcount + int'(m_push)) % LAP;
      m_wtotal = m_wtotal + int'(m_push);
      occ      = (m_wcount - g2b(sync_q[0]) + LAP) % LAP;
      m_full   = (occ == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
      m_af     = (occ >= DEPTH - AFM);
`else
      m_af     = 0;
`endif
      void'(sync_q.pop_front());
      sync_q.push_back(rd_i);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs for one edge, advance the model, sample #1 after edge
  task automatic step(input logic rst_n_i, input logic en_i, input logic [PW-1:0] rd_i);
    wr_rst_n        = rst_n_i;
    bus.wr_en       = en_i;
    bus.rd_ptr_gray = rd_i;
    @(posedge wr_clk);
    model_update(rst_n_i, en_i, rd_i);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"}, int'(bus.wr_addr),        m_wcount % DEPTH);
    check({tag, ".gray"}, int'(bus.wr_ptr_gray),    int'(b2g(m_wcount)));
    check({tag, ".full"}, int'(bus.wr_full),        int'(m_full));
    check({tag, ".af"},   int'(bus.wr_almost_full), int'(m_af));
  endtask

  typedef struct {
    logic          rst_n;
    logic          en;
    logic [PW-1:0] rd;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_gray;
    logic          e_full;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [PW-1:0] prev_gray;
    logic [PW-1:0] rd_g;
    int rcount;
    int wraps;
    int af_exp;

    wr_rst_n        = 1'b0;
    bus.wr_en       = 1'b0;
    bus.rd_ptr_gray = '0;
    sync_q          = {'0, '0};

    vecs[0] = '{1'b0, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'b00000, 4'd1, 5'b00001, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 5'b00000, 4'd1, 5'b00001, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'b00000, 4'd2, 5'b00011, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'b00000, 4'd3, 5'b00010, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0};

    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].rd);
      check($sformatf("vec%0d.addr", i), int'(bus.wr_addr),     int'(vecs[i].e_addr));
      check($sformatf("vec%0d.gray", i), int'(bus.wr_ptr_gray), int'(vecs[i].e_gray));
      check($sformatf("vec%0d.full", i), int'(bus.wr_full),     int'(vecs[i].e_full));
      check($sformatf("vec%0d.af", i),   int'(bus.wr_almost_full), 0);
    end

    // fill to 16 with rd=0; almost-full at 14, full exactly at 16
`ifdef FIFO_ALMOST_FULL_EN
    af_exp = 1;
`else
    af_exp = 0;
`endif
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b1, '0);
      check($sformatf("fill%0d.full", i), int'(bus.wr_full), (i == DEPTH) ? 1 : 0);
      if (i == 13) check("fill13.af", int'(bus.wr_almost_full), 0);
      if (i == 14) check("fill14.af", int'(bus.wr_almost_full), af_exp);
    end
    check("full.addr", int'(bus.wr_addr),     0);
    check("full.gray", int'(bus.wr_ptr_gray), 5'b11000);

    // writes while full are dropped
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, '0);
      check($sformatf("hold%0d.addr", i), int'(bus.wr_addr),     0);
      check($sformatf("hold%0d.gray", i), int'(bus.wr_ptr_gray), 5'b11000);
      check($sformatf("hold%0d.full", i), int'(bus.wr_full),     1);
    end

    // one read: full drops exactly on the 3rd edge, refills on next push
    for (int e = 1; e <= 3; e++) begin
      step(1'b1, 1'b0, 5'b00001);
      check($sformatf("rel_edge%0d.full", e), int'(bus.wr_full), (e == 3) ? 0 : 1);
    end
    step(1'b1, 1'b1, 5'b00001);
    check("refill.addr", int'(bus.wr_addr), 1);
    check("refill.full", int'(bus.wr_full), 1);

    // random interleaved traffic against the model, from a fresh reset
    step(1'b0, 1'b0, '0);
    check_model("rst");
    rcount    = 0;
    wraps     = 0;
    prev_gray = bus.wr_ptr_gray;
    for (int c = 0; c < 400; c++) begin
      if (rcount < m_wtotal && $urandom_range(0, 99) < 35) rcount++;
      rd_g = b2g(rcount);
      step(1'b1, ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0, rd_g);
      check_model($sformatf("rnd%0d", c));
      check($sformatf("rnd%0d.hamming", c), $countones(bus.wr_ptr_gray ^ prev_gray), int'(m_push));
      if (prev_gray == 5'b10000 && bus.wr_ptr_gray == 5'b00000) wraps++;
      prev_gray = bus.wr_ptr_gray;
    end
    check("laps_ge_2", (m_wtotal >= 2 * LAP) ? 1 : 0, 1);
    check("wrap_seen", (wraps >= 1) ? 1 : 0, 1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
